// File: rtl/cdb_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_rr_if
//  Description : Bundle of result-source inputs and CDB broadcast outputs for
//                cdb_arbiter_rr.
//                slave  : the arbiter (consumes src_*, drives src_ready/cdb_*)
//                master : the functional-unit / consumer side
//  Ports       : src_valid/src_tag/src_data/src_rob_idx (per source, packed,
//                source 0 in LSBs), src_ready (FU avail), cdb_valid/cdb_tag/
//                cdb_data/cdb_rob_idx (per channel, packed), rr_ptr_dbg
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_rr_if #(
    parameter int NUM_SRC = 8,
    parameter int NUM_CDB = 3,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 5
) ();
    localparam int c_ptr_w = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC*ROB_W-1:0]  src_rob_idx;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic [NUM_CDB*ROB_W-1:0]  cdb_rob_idx;
    logic [c_ptr_w-1:0]        rr_ptr_dbg;

    modport master (
        output src_valid, src_tag, src_data, src_rob_idx,
        input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_rob_idx, rr_ptr_dbg
    );

    modport slave (
        input  src_valid, src_tag, src_data, src_rob_idx,
        output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_rob_idx, rr_ptr_dbg
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_rr
//  Description : Common data bus select stage. Each result source owns a
//                one-entry holding slot; every cycle up to NUM_CDB occupied
//                slots are granted (rotating round-robin or fixed priority)
//                and broadcast on registered CDB channels.
//  Ports       : clock, reset (sync, active-high), squash (sync flush),
//                bus (cdb_arbiter_rr_if.slave: source inputs, src_ready,
//                CDB channel outputs, rr_ptr_dbg)
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter_rr #(
    parameter int NUM_SRC = 8,
    parameter int NUM_CDB = 3,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 5,
    parameter int RR_MODE = 1
) (
    input wire clock,
    input wire reset,
    input wire squash,
    cdb_arbiter_rr_if.slave bus
);
    localparam int c_ptr_w = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Holding slots
    logic [NUM_SRC-1:0] r_slot_valid;
    logic [TAG_W-1:0]   r_slot_tag  [NUM_SRC];
    logic [DATA_W-1:0]  r_slot_data [NUM_SRC];
    logic [ROB_W-1:0]   r_slot_rob  [NUM_SRC];

    // Broadcast channel registers, stored packed in port layout
    logic [NUM_CDB-1:0]        r_cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  r_cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] r_cdb_data;
    logic [NUM_CDB*ROB_W-1:0]  r_cdb_rob;

    logic [c_ptr_w-1:0] r_rr_ptr;

    // Selection results
    logic [NUM_SRC-1:0] w_grant;
    logic [NUM_SRC-1:0] w_ready;
    logic [NUM_SRC-1:0] w_ch_sel [NUM_CDB];   // one-hot source per channel
    logic [NUM_CDB-1:0] w_ch_valid;
    logic [TAG_W-1:0]   w_ch_tag  [NUM_CDB];
    logic [DATA_W-1:0]  w_ch_data [NUM_CDB];
    logic [ROB_W-1:0]   w_ch_rob  [NUM_CDB];
    logic [c_ptr_w-1:0] w_ptr_nxt;

    // Scan the slots starting at the pointer (or 0), wrapping modulo NUM_SRC.
    // The k-th occupied slot found is granted onto channel k, so channels
    // fill from the bottom. The pointer follows the last granted slot.
    always_comb begin
        int v_start;
        int v_src;
        int v_cnt;
        w_grant    = '0;
        w_ch_valid = '0;
        w_ptr_nxt  = r_rr_ptr;
        for (int c = 0; c < NUM_CDB; c++) begin
            w_ch_sel[c] = '0;
        end
        v_cnt   = 0;
        v_src   = 0;
        v_start = (RR_MODE != 0) ? int'(r_rr_ptr) : 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            v_src = v_start + k;
            if (v_src >= NUM_SRC) begin
                v_src = v_src - NUM_SRC;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (v_src == i && r_slot_valid[i] && v_cnt < NUM_CDB) begin
                    w_grant[i] = 1'b1;
                    for (int c = 0; c < NUM_CDB; c++) begin
                        if (v_cnt == c) begin
                            w_ch_valid[c]  = 1'b1;
                            w_ch_sel[c][i] = 1'b1;
                        end
                    end
                    w_ptr_nxt = (i == NUM_SRC - 1) ? '0 : c_ptr_w'(i + 1);
                    v_cnt     = v_cnt + 1;
                end
            end
        end
    end

    // Payload mux per channel from its one-hot source select
    always_comb begin
        for (int c = 0; c < NUM_CDB; c++) begin
            w_ch_tag[c]  = '0;
            w_ch_data[c] = '0;
            w_ch_rob[c]  = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_ch_sel[c][i]) begin
                    w_ch_tag[c]  = r_slot_tag[i];
                    w_ch_data[c] = r_slot_data[i];
                    w_ch_rob[c]  = r_slot_rob[i];
                end
            end
        end
    end

    // A slot draining this cycle can take a new result at the same edge,
    // so ready does not depend on src_valid and there is no bubble.
    assign w_ready = ~r_slot_valid | w_grant;

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            r_slot_valid <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_slot_tag[i]  <= '0;
                r_slot_data[i] <= '0;
                r_slot_rob[i]  <= '0;
            end
            r_cdb_valid <= '0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_rob   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.src_valid[i] && w_ready[i]) begin
                    r_slot_valid[i] <= 1'b1;
                    r_slot_tag[i]   <= bus.src_tag[i*TAG_W +: TAG_W];
                    r_slot_data[i]  <= bus.src_data[i*DATA_W +: DATA_W];
                    r_slot_rob[i]   <= bus.src_rob_idx[i*ROB_W +: ROB_W];
                end else if (w_grant[i]) begin
                    r_slot_valid[i] <= 1'b0;
                end
            end
            r_cdb_valid <= w_ch_valid;
            for (int c = 0; c < NUM_CDB; c++) begin
                r_cdb_tag[c*TAG_W +: TAG_W]    <= w_ch_tag[c];
                r_cdb_data[c*DATA_W +: DATA_W] <= w_ch_data[c];
                r_cdb_rob[c*ROB_W +: ROB_W]    <= w_ch_rob[c];
            end
            // Fixed-priority builds keep the pointer parked at 0
            if (RR_MODE != 0 && (|w_grant)) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus.src_ready   = w_ready;
    assign bus.cdb_valid   = r_cdb_valid;
    assign bus.cdb_tag     = r_cdb_tag;
    assign bus.cdb_data    = r_cdb_data;
    assign bus.cdb_rob_idx = r_cdb_rob;
    assign bus.rr_ptr_dbg  = r_rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter_rr
//  Description : Bench for cdb_arbiter_rr. Three builds share one stimulus:
//                A = 8 src / 3 cdb / round-robin, B = 8 / 3 / fixed priority,
//                C = 4 / 4 / round-robin (driven by sources 0..3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter_rr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       squash;
    logic [7:0] s_valid;
    logic [5:0]  s_tag  [8];
    logic [31:0] s_data [8];
    logic [4:0]  s_rob  [8];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    cdb_arbiter_rr_if #(.NUM_SRC(8), .NUM_CDB(3)) if_a ();
    cdb_arbiter_rr_if #(.NUM_SRC(8), .NUM_CDB(3)) if_b ();
    cdb_arbiter_rr_if #(.NUM_SRC(4), .NUM_CDB(4)) if_c ();

    always_comb begin
        if_a.src_valid = s_valid;
        if_b.src_valid = s_valid;
        if_c.src_valid = s_valid[3:0];
        for (int i = 0; i < 8; i++) begin
            if_a.src_tag[i*6 +: 6]       = s_tag[i];
            if_a.src_data[i*32 +: 32]    = s_data[i];
            if_a.src_rob_idx[i*5 +: 5]   = s_rob[i];
            if_b.src_tag[i*6 +: 6]       = s_tag[i];
            if_b.src_data[i*32 +: 32]    = s_data[i];
            if_b.src_rob_idx[i*5 +: 5]   = s_rob[i];
        end
        for (int i = 0; i < 4; i++) begin
            if_c.src_tag[i*6 +: 6]       = s_tag[i];
            if_c.src_data[i*32 +: 32]    = s_data[i];
            if_c.src_rob_idx[i*5 +: 5]   = s_rob[i];
        end
    end

    cdb_arbiter_rr #(.NUM_SRC(8), .NUM_CDB(3), .TAG_W(6), .DATA_W(32), .ROB_W(5), .RR_MODE(1))
        dut_a (.clock(clk), .reset(rst), .squash(squash), .bus(if_a.slave));
    cdb_arbiter_rr #(.NUM_SRC(8), .NUM_CDB(3), .TAG_W(6), .DATA_W(32), .ROB_W(5), .RR_MODE(0))
        dut_b (.clock(clk), .reset(rst), .squash(squash), .bus(if_b.slave));
    cdb_arbiter_rr #(.NUM_SRC(4), .NUM_CDB(4), .TAG_W(6), .DATA_W(32), .ROB_W(5), .RR_MODE(1))
        dut_c (.clock(clk), .reset(rst), .squash(squash), .bus(if_c.slave));

    // ---------------- behavioural model ----------------
    int cfg_n  [3] = '{8, 8, 4};
    int cfg_c  [3] = '{3, 3, 4};
    int cfg_rr [3] = '{1, 0, 1};

    bit          m_occ  [3][8];
    logic [5:0]  m_tag  [3][8];
    logic [31:0] m_data [3][8];
    logic [4:0]  m_rob  [3][8];
    int          m_ptr  [3];
    bit          m_cv   [3][4];
    logic [5:0]  m_ct   [3][4];
    logic [31:0] m_cd   [3][4];
    logic [4:0]  m_cr   [3][4];

    // Occupied slots in scan order; the first NUM_CDB of them win.
    function automatic int grant_list(input int d, output int lst[4]);
        int q[$];
        int start;
        int n;
        start = (cfg_rr[d] != 0) ? m_ptr[d] : 0;
        for (int k = 0; k < cfg_n[d]; k++) begin
            if (m_occ[d][(start + k) % cfg_n[d]]) q.push_back((start + k) % cfg_n[d]);
        end
        n = (q.size() < cfg_c[d]) ? q.size() : cfg_c[d];
        for (int j = 0; j < 4; j++) lst[j] = (j < n) ? q[j] : -1;
        return n;
    endfunction

    function automatic logic [7:0] exp_ready(input int d);
        int lst[4];
        int n;
        logic [7:0] r;
        r = '0;
        n = grant_list(d, lst);
        for (int s = 0; s < cfg_n[d]; s++) if (!m_occ[d][s]) r[s] = 1'b1;
        for (int j = 0; j < n; j++) r[lst[j]] = 1'b1;
        return r;
    endfunction

    task automatic model_step(input int d);
        int lst[4];
        int n;
        logic [7:0] rdy;
        n   = grant_list(d, lst);
        rdy = exp_ready(d);
        if (rst || squash) begin
            for (int s = 0; s < 8; s++) begin
                m_occ[d][s] = 1'b0; m_tag[d][s] = '0; m_data[d][s] = '0; m_rob[d][s] = '0;
            end
            for (int j = 0; j < 4; j++) m_cv[d][j] = 1'b0;
            m_ptr[d] = 0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                m_cv[d][j] = (j < n);
                if (j < n) begin
                    m_ct[d][j] = m_tag[d][lst[j]];
                    m_cd[d][j] = m_data[d][lst[j]];
                    m_cr[d][j] = m_rob[d][lst[j]];
                end
            end
            if (cfg_rr[d] != 0 && n > 0) m_ptr[d] = (lst[n-1] + 1) % cfg_n[d];
            for (int s = 0; s < cfg_n[d]; s++) begin
                if (s_valid[s] && rdy[s]) begin
                    m_occ[d][s] = 1'b1; m_tag[d][s] = s_tag[s];
                    m_data[d][s] = s_data[s]; m_rob[d][s] = s_rob[s];
                end else if (m_occ[d][s] && rdy[s]) begin
                    m_occ[d][s] = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) model_step(d);
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_dut(input int d, input logic [127:0] cv, input logic [127:0] ct,
                           input logic [127:0] cdat, input logic [127:0] cr,
                           input logic [127:0] rdy, input logic [127:0] ptr);
        logic [3:0] ecv;
        for (int j = 0; j < 4; j++) ecv[j] = m_cv[d][j];
        check($sformatf("d%0d_cdb_valid", d), cv, 128'(ecv));
        for (int j = 0; j < cfg_c[d]; j++) begin
            if (m_cv[d][j]) begin
                check($sformatf("d%0d_ch%0d_payload", d, j),
                      128'({ct[j*6 +: 6], cdat[j*32 +: 32], cr[j*5 +: 5]}),
                      128'({m_ct[d][j], m_cd[d][j], m_cr[d][j]}));
            end
        end
        check($sformatf("d%0d_src_ready", d), rdy, 128'(exp_ready(d)));
        check($sformatf("d%0d_rr_ptr", d), ptr, 128'(m_ptr[d]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, 128'(if_a.cdb_valid), 128'(if_a.cdb_tag), 128'(if_a.cdb_data),
                    128'(if_a.cdb_rob_idx), 128'(if_a.src_ready), 128'(if_a.rr_ptr_dbg));
            cmp_dut(1, 128'(if_b.cdb_valid), 128'(if_b.cdb_tag), 128'(if_b.cdb_data),
                    128'(if_b.cdb_rob_idx), 128'(if_b.src_ready), 128'(if_b.rr_ptr_dbg));
            cmp_dut(2, 128'(if_c.cdb_valid), 128'(if_c.cdb_tag), 128'(if_c.cdb_data),
                    128'(if_c.cdb_rob_idx), 128'(if_c.src_ready), 128'(if_c.rr_ptr_dbg));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_all(input int cy);
        for (int i = 0; i < 8; i++) begin
            s_tag[i]  = 6'(i + 1);
            s_rob[i]  = 5'(i);
            s_data[i] = 32'hA000_0000 | (32'(cy) << 8) | 32'(i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; squash = 1'b0; s_valid = '0;
        for (int i = 0; i < 8; i++) begin
            s_tag[i] = '0; s_data[i] = '0; s_rob[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        check("rst_ready_a", 128'(if_a.src_ready), 128'(8'hFF));
        check("rst_cdb_valid_a", 128'(if_a.cdb_valid), 128'(3'b000));
        check("rst_ptr_a", 128'(if_a.rr_ptr_dbg), 128'(3'd0));

        // Single result from source 2
        s_valid = 8'h04; s_tag[2] = 6'h11; s_data[2] = 32'hDEAD_BEEF; s_rob[2] = 5'd4;
        @(negedge clk);
        s_valid = 8'h00;
        @(negedge clk);
        check("t1_cdb_valid_a", 128'(if_a.cdb_valid), 128'(3'b001));
        check("t1_tag_a", 128'(if_a.cdb_tag[5:0]), 128'(6'h11));
        check("t1_data_a", 128'(if_a.cdb_data[31:0]), 128'(32'hDEAD_BEEF));
        check("t1_rob_a", 128'(if_a.cdb_rob_idx[4:0]), 128'(5'd4));
        check("t1_ptr_a", 128'(if_a.rr_ptr_dbg), 128'(3'd3));
        check("t1_ptr_b", 128'(if_b.rr_ptr_dbg), 128'(3'd0));
        check("t1_ptr_c", 128'(if_c.rr_ptr_dbg), 128'(2'd3));
        @(negedge clk);
        check("t1_empty_a", 128'(if_a.cdb_valid), 128'(3'b000));

        // All sources valid every cycle
        do_reset();
        s_valid = 8'hFF;
        drive_all(0);
        @(negedge clk);
        check("t2_ready_a_fill", 128'(if_a.src_ready), 128'(8'h07));
        check("t2_ready_b_fill", 128'(if_b.src_ready), 128'(8'h07));
        drive_all(1);
        @(negedge clk);
        check("t2_tags_a_0", 128'(if_a.cdb_tag), 128'({6'd3, 6'd2, 6'd1}));
        check("t2_data_a_0", 128'(if_a.cdb_data[31:0]), 128'(32'hA000_0000));
        check("t2_ptr_a_0", 128'(if_a.rr_ptr_dbg), 128'(3'd3));
        check("t2_ready_a_0", 128'(if_a.src_ready), 128'(8'h38));
        check("t2_cdb_valid_c_0", 128'(if_c.cdb_valid), 128'(4'hF));
        drive_all(2);
        @(negedge clk);
        check("t2_tags_a_1", 128'(if_a.cdb_tag), 128'({6'd6, 6'd5, 6'd4}));
        check("t2_ptr_a_1", 128'(if_a.rr_ptr_dbg), 128'(3'd6));
        check("t2_ready_a_1", 128'(if_a.src_ready), 128'(8'hC1));
        drive_all(3);
        @(negedge clk);
        check("t2_tags_a_2", 128'(if_a.cdb_tag), 128'({6'd1, 6'd8, 6'd7}));
        check("t2_ptr_a_2", 128'(if_a.rr_ptr_dbg), 128'(3'd1));
        check("t3_tags_b", 128'(if_b.cdb_tag), 128'({6'd3, 6'd2, 6'd1}));
        check("t3_ready_b", 128'(if_b.src_ready), 128'(8'h07));
        check("t6_cdb_valid_c", 128'(if_c.cdb_valid), 128'(4'hF));
        check("t6_ready_c", 128'(if_c.src_ready), 128'(4'hF));
        s_valid = 8'h00;

        // Back-to-back results from source 5
        do_reset();
        s_valid = 8'h20; s_tag[5] = 6'h25; s_rob[5] = 5'd5; s_data[5] = 32'h5555_0001;
        @(negedge clk);
        check("t4_ready_a", 128'(if_a.src_ready), 128'(8'hFF));
        s_data[5] = 32'h5555_0002;
        @(negedge clk);
        s_valid = 8'h00;
        check("t4_first_valid", 128'(if_a.cdb_valid), 128'(3'b001));
        check("t4_first_data", 128'(if_a.cdb_data[31:0]), 128'(32'h5555_0001));
        @(negedge clk);
        check("t4_second_valid", 128'(if_a.cdb_valid), 128'(3'b001));
        check("t4_second_data", 128'(if_a.cdb_data[31:0]), 128'(32'h5555_0002));
        check("t4_ptr_a", 128'(if_a.rr_ptr_dbg), 128'(3'd6));
        @(negedge clk);

        // Squash with slots 1, 4, 6 occupied
        do_reset();
        drive_all(7);
        s_valid = 8'h52;
        @(negedge clk);
        squash = 1'b1;
        s_valid = 8'h01;
        @(negedge clk);
        squash = 1'b0;
        s_valid = 8'h00;
        check("t5_cdb_valid_a", 128'(if_a.cdb_valid), 128'(3'b000));
        check("t5_ready_a", 128'(if_a.src_ready), 128'(8'hFF));
        check("t5_ptr_a", 128'(if_a.rr_ptr_dbg), 128'(3'd0));
        check("t5_ready_c", 128'(if_c.src_ready), 128'(4'hF));
        @(negedge clk);
        check("t5_dropped_a", 128'(if_a.cdb_valid), 128'(3'b000));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cdb_arbiter_rr.md
Name: cdb_arbiter_rr

Overview:
- Parametrised successor to the fixed ALU/MULT/LOAD common data bus (CDB) select stage.
- Each functional-unit result source gets a one-entry holding slot.
- Each cycle, up to NUM_CDB occupied slots are granted. Selection is round-robin or fixed priority.
- Granted results are broadcast on registered CDB channels that feed the physical register file (PRF), reservation stations (RS) and reorder buffer (ROB). Per-source ready is returned as the FU "avail" backpressure.

Parameters:
- NUM_SRC, 8, number of result sources (FUs); 1..16.
- NUM_CDB, 3, number of broadcast channels; 1..NUM_SRC.
- TAG_W, 6, physical register tag width.
- DATA_W, 32, result value width.
- ROB_W, 5, ROB index width.
- RR_MODE, 1, 1 = rotating round-robin priority; 0 = fixed priority, lowest index first.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  synchronous flush, same effect as reset
- src_valid  in  NUM_SRC  source i presents a completed result
- src_tag  in  NUM_SRC*TAG_W  destination tag per source, packed, source 0 in LSBs
- src_data  in  NUM_SRC*DATA_W  result value per source, packed
- src_rob_idx  in  NUM_SRC*ROB_W  ROB index per source, packed
- src_ready  out  NUM_SRC  slot i can accept (FU avail)
- cdb_valid  out  NUM_CDB  channel c broadcasting
- cdb_tag  out  NUM_CDB*TAG_W  broadcast tag per channel
- cdb_data  out  NUM_CDB*DATA_W  broadcast value per channel
- cdb_rob_idx  out  NUM_CDB*ROB_W  broadcast ROB index per channel
- rr_ptr_dbg  out  clog2(NUM_SRC)  current round-robin start pointer

Behaviour:

Slots:
- Per source: slot_valid, tag, data and rob_idx registers.
- src_ready[i] = !slot_valid[i] || grant[i]. It is combinational and has no dependence on src_valid.
- Capture: src_valid[i] && src_ready[i] at edge t loads the slot.
- When grant and capture happen in the same cycle, the new result is loaded into the slot; no bubble.

Selection (combinational from slot state):
- Scan order starts at rr_ptr when RR_MODE=1, otherwise at 0. The scan wraps modulo NUM_SRC.
- The first NUM_CDB occupied slots in scan order are granted.
- The k-th grant in scan order drives channel k. Channels are packed low; unused channels are invalid.

Broadcast:
- Channel registers load from granted slots at the edge.
- Latency: captured at edge t, broadcast visible in cycle after edge t+1 if granted immediately. Minimum 2 edges from src_valid to cdb_valid.
- cdb_valid is held for exactly one cycle per grant; there is no output backpressure.

Round-robin pointer:
- If any grant occurs, rr_ptr <= (index of last granted slot + 1) mod NUM_SRC.
- If no grant occurs, rr_ptr holds.
- In RR_MODE=0, rr_ptr stays 0.

Starvation guarantee (RR_MODE=1):
- A continuously occupied slot is granted within ceil(NUM_SRC/NUM_CDB) cycles.

Reset / squash:
- At the edge: all slot_valid <= 0, cdb_valid <= 0, rr_ptr <= 0.
- Tag, data and rob_idx registers reset to 0.
- src_valid in the reset/squash cycle is dropped (not captured).
- After reset, src_ready is all-ones.

Boundary conditions:
- All slots empty: no cdb_valid next cycle.
- Occupied slots ≤ NUM_CDB: all are granted; no source waits.
- NUM_CDB = NUM_SRC: every occupied slot is granted each cycle, and src_ready stays all-ones.
- The pointer wraps from NUM_SRC-1 to 0.

Width rules:
- Payload is passed through unmodified.
- A tag of 0 is broadcast like any other tag; the consumer ignores it.

Test Plan:
1. Reset, then NUM_SRC=8, NUM_CDB=3, RR_MODE=1. Single src_valid[2]=1, tag 0x11, data 0xDEADBEEF, rob_idx 4 for one cycle -> two edges later cdb_valid=3'b001, channel 0 carries 0x11/0xDEADBEEF/4. rr_ptr_dbg=3.
2. All 8 sources valid every cycle, rr_ptr=0 -> grants are {0,1,2}, then {3,4,5}, then {6,7,0}. Every source is granted within 3 cycles. src_ready deasserts only on ungranted occupied slots.
3. Same as 2 with RR_MODE=0 -> channels always carry sources 0,1,2. src_ready[7:3]=0 after the first fill.
4. Slot 5 occupied and granted while src_valid[5] presents a new result in the same cycle -> src_ready[5]=1, new result captured. Two consecutive broadcasts from source 5 in back-to-back cycles.
5. Slots 1, 4 and 6 occupied and squash asserted -> next cycle cdb_valid=0, src_ready=8'hFF, rr_ptr_dbg=0. A src_valid asserted during the squash cycle is never broadcast.
6. NUM_CDB=NUM_SRC=4 build, all valid every cycle -> cdb_valid=4'b1111 each cycle and src_ready stays 4'hF throughout.
